// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one Avalon-MM master port between two requesters
module mem_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic [1:0]        r0_mode,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic [1:0]        r1_mode,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic [1:0]        grant
);
  typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, DONE} state_t;
  state_t                 state_q, state_d;
  logic                   last_q, last_d, pick, owner;
  logic [1:0]             req, el, mode, blk_q, blk_d, gnt_q, gnt_d, err_q, err_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]             cnt_q, cnt_d;
  assign req   = {r1_req, r0_req};
  assign el    = req & ~blk_q;
  assign pick  = el[1] & (~el[0] | ~last_q);
  assign owner = gnt_q[1];
  assign mode  = pick ? r1_mode : r0_mode;
  // Arbitration, transaction sequencing and per-requester result capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    blk_d   = (blk_q | (state_q == DONE ? gnt_q : 2'b00)) & req;
    case (state_q)
      IDLE: if (|el) begin
        gnt_d   = pick ? 2'b10 : 2'b01;
        last_d  = pick;
        addr_d  = pick ? r1_addr : r0_addr;
        wdata_d = pick ? r1_wdata : r0_wdata;
        state_d = mode == 2'b01 ? ISSUE_RD : mode == 2'b10 ? ISSUE_WR : DONE;
        if (mode == 2'b00 || mode == 2'b11) err_d[pick] = 1'b1;
      end
      ISSUE_RD: if (!avm_waitrequest) begin
        state_d = WAIT_RD;
        cnt_d   = '0;
      end
      WAIT_RD: begin
        cnt_d = cnt_q + 8'd1;
        if (avm_readdatavalid) begin
          state_d        = DONE;
          rdata_d[owner] = avm_readdata;
          err_d[owner]   = 1'b0;
        end else if (cnt_d == 8'(TIMEOUT)) begin
          state_d        = DONE;
          rdata_d[owner] = DATA_W'(16'hDEAD);
          err_d[owner]   = 1'b1;
        end
      end
      ISSUE_WR: if (!avm_waitrequest) begin
        state_d      = DONE;
        err_d[owner] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      blk_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      blk_q   <= blk_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign grant         = busy ? gnt_q : 2'b00;
  assign avm_read      = state_q == ISSUE_RD;
  assign avm_write     = state_q == ISSUE_WR;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign r0_done       = state_q == DONE && gnt_q[0];
  assign r1_done       = state_q == DONE && gnt_q[1];
  assign r0_rdata      = rdata_q[0];
  assign r1_rdata      = rdata_q[1];
  assign r0_err        = err_q[0];
  assign r1_err        = err_q[1];
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the external memory port between two requesters. Requester 0 is the switch/key I/O controller; requester 1 is a second client such as a scan or test engine. Each requester presents a mode, an address, write data and a level request. The block grants one request at a time round-robin, drives a pipelined Avalon-MM style master (waitrequest / readdatavalid), and returns a one-cycle done pulse plus held read data to the granted requester. It sits between the I/O controller's memory outputs and the memory interface.

## Interface
- ADDR_W, 25, address width
- DATA_W, 16, data width
- TIMEOUT, 255, max cycles to wait for readdatavalid (8-bit counter)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- rN_req  in  1  level request, held until rN_done, N∈{0,1}
- rN_mode  in  2  01 read, 10 write, 00/11 illegal
- rN_addr  in  ADDR_W  address, stable while rN_req high
- rN_wdata  in  DATA_W  write data, stable while rN_req high
- rN_done  out  1  one-cycle completion pulse
- rN_rdata  out  DATA_W  last read result for requester N, held until its next read completes
- rN_err  out  1  set with rN_done on timeout or illegal mode, cleared on next rN_done
- avm_address  out  ADDR_W  memory address
- avm_read  out  1  read command
- avm_write  out  1  write command
- avm_writedata  out  DATA_W  write data
- avm_waitrequest  in  1  command stall
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  high in any state other than IDLE
- grant  out  2  one-hot owner of the current transaction, 00 when idle

## Operation
- States: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, DONE.
- Eligibility: requester N is eligible when rN_req=1 and blk[N]=0.
  - blk[N] sets in DONE for the granted requester.
  - blk[N] clears on any cycle rN_req is sampled 0.
  - This prevents re-servicing a request whose level drops one cycle after done.
- Arbitration (IDLE only):
  - Pointer `last` holds the last granted requester.
  - If both are eligible, grant the one ≠ last.
  - If one is eligible, grant it.
  - Grant latches address, write data, mode and grant; `last` updates.
- IDLE → ISSUE_RD (mode 01), ISSUE_WR (mode 10), or DONE with err=1 and no bus access (mode 00/11).
- ISSUE_RD: avm_read=1, avm_address driven. When avm_waitrequest=0, go to WAIT_RD and clear the timeout counter.
- WAIT_RD: on avm_readdatavalid, capture avm_readdata into rN_rdata and go to DONE.
  - The counter increments each cycle.
  - When the counter reaches TIMEOUT, go to DONE with err=1, rdata=16'hDEAD.
- ISSUE_WR: avm_write=1, address and data driven. When avm_waitrequest=0, go to DONE.
- DONE: rN_done=1 for the granted requester for exactly one cycle, then IDLE.
- avm_readdatavalid outside WAIT_RD is ignored; this covers stale data after a timeout or reset.
- Requests are never aborted. Deasserting rN_req mid-transaction does not cancel it; done still pulses.

## Timing
- Reset (reset_n=0 at an edge) forces:
  - state=IDLE, last=1 (requester 0 wins first tie), blk=00
  - all outputs 0, including rN_rdata, rN_err, avm_*, grant, busy
- Reset mid-transaction abandons it. No done pulse is issued.
- Commands are registered. avm_read/avm_write rise the cycle after the grant and hold until sampled with avm_waitrequest=0. Address and data stay stable throughout.
- Write latency: req sampled at edge 0 → avm_write high in cycle 1 → done in cycle 2 (zero wait). Each waitrequest cycle adds 1.
- Read latency: done appears one cycle after the readdatavalid cycle. The earliest readdatavalid is the cycle after command accept.
- Illegal mode: done one cycle after grant.
- Back-to-back throughput: the next grant occurs in the IDLE cycle after DONE. A minimum of 3 cycles per write.
- If both requests arrive in the same cycle that a requester's blk clears, the blocked requester is not eligible that cycle.

## Test plan
- Single write: r0 mode=10, addr=0x0000123, wdata=0xBEEF, waitrequest=0 → avm_write one cycle with those values, r0_done 2 cycles after req, r0_err=0.
- Read with latency: r1 mode=01, addr=0x1FFFFFF, waitrequest high 2 cycles, readdatavalid 3 cycles after accept with 0x5A5A → r1_rdata=0x5A5A, r1_done one cycle after valid, r0_done never pulses.
- Contention: r0 and r1 both request from reset and hold continuously (re-raising after one low cycle) → grants alternate r0, r1, r0, r1. No requester is serviced twice while its req stays high.
- Timeout: read with readdatavalid never asserted → r0_done after TIMEOUT cycles in WAIT_RD, r0_err=1, r0_rdata=0xDEAD. A late readdatavalid is ignored.
- Illegal mode: r0 mode=00, req=1 → no avm_read/avm_write, r0_done with r0_err=1 one cycle after grant.
- Reset mid-read: assert reset_n=0 in WAIT_RD → next cycle all outputs 0, no done pulse. A subsequent read completes normally.
